// File: rtl/ram_delay_stream_ctrl_if.sv
// Stream/delay-line bundle for ram_delay_stream_ctrl.
//   in_*     : upstream valid/ready stream into the controller
//   delay_*  : connection to the attached ram_delay_reg
//   out_*    : downstream valid/ready stream out of the 2-entry buffer
//   occupancy: valid words held in the line plus the buffer
// slave  : the controller's view
// master : the surrounding environment's view (source, sink and delay line)
interface ram_delay_stream_ctrl_if #(
  parameter int WIDTH = 64,
  parameter int CNTW  = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             delay_enable;
  logic [WIDTH-1:0] delay_din;
  logic [WIDTH-1:0] delay_dout;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CNTW-1:0]  occupancy;

  modport slave (
    input  in_valid, in_data, delay_dout, out_ready,
    output in_ready, delay_enable, delay_din, out_valid, out_data, occupancy
  );

  modport master (
    output in_valid, in_data, delay_dout, out_ready,
    input  in_ready, delay_enable, delay_din, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/ram_delay_stream_ctrl.sv
// Flow-control wrapper for the RAM delay line (ram_delay_reg).
// Turns an upstream valid/ready stream into the line's single advance enable,
// tags each slot valid or bubble, and pops valid delayed words into a 2-entry
// output buffer drained by a downstream valid/ready consumer.
// Ports:
//   clock : rising-edge clock
//   rst   : asynchronous active-high reset
//   s     : stream / delay-line bundle (ram_delay_stream_ctrl_if.slave)
module ram_delay_stream_ctrl #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 64,
  parameter int DRAIN = 1,
  parameter int CNTW  = 4
) (
  input  logic                    clock,
  input  logic                    rst,
  ram_delay_stream_ctrl_if.slave  s
);
  logic [DEPTH-1:0] vtag;   // slot-valid tags, vtag[DEPTH-1] aligns with delay_dout
  logic [1:0]       count;  // buffer fill 0..2
  logic [WIDTH-1:0] head, tail;
  logic [CNTW-1:0]  occ;

  logic vtop, can_adv, adv, accept, push, pop;

  assign vtop    = vtag[DEPTH-1];
  // Only registered terms: no combinational out_ready -> in_ready path.
  assign can_adv = !vtop || (count < 2'd2);
  // Bubble advances keep in-flight words moving when input is idle.
  assign adv     = !rst && can_adv && (s.in_valid || ((DRAIN != 0) && (|vtag)));
  assign accept  = s.in_valid && can_adv;
  assign push    = adv && vtop;
  assign pop     = (count != 2'd0) && s.out_ready;

  assign s.in_ready     = can_adv;
  assign s.delay_enable = adv;
  assign s.delay_din    = s.in_data;
  assign s.out_valid    = (count != 2'd0);
  assign s.out_data     = head;
  assign s.occupancy    = occ;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      vtag  <= '0;
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
      occ   <= '0;
    end else begin
      if (adv) vtag <= {vtag[DEPTH-2:0], s.in_valid};

      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= s.delay_dout;
          else               tail <= s.delay_dout;
          count <= count + 2'd1;
        end
        2'b01: begin
          // head keeps its last value once the buffer empties
          if (count == 2'd2) head <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) head <= s.delay_dout;
          else begin
            head <= tail;
            tail <= s.delay_dout;
          end
        end
        default: ;
      endcase

      case ({accept, pop})
        2'b10:   occ <= occ + CNTW'(1);
        2'b01:   occ <= occ - CNTW'(1);
        default: ;
      endcase
    end
  end
endmodule
